// File: rtl/maze_probe_sequencer.sv
// Once per frame, walks every sprite's five wall probes through one shared maze ROM
// read port and publishes the collected wall flags atomically at the end of the scan.
module maze_probe_sequencer #(
  parameter int unsigned NUM_SPRITES = 5,
  parameter int unsigned ROM_LAT     = 2
) (
  input  logic                       vga_clk,
  input  logic                       Reset_n,
  input  logic                       frame_start,
  input  logic [10*NUM_SPRITES-1:0]  pos_x,
  input  logic [10*NUM_SPRITES-1:0]  pos_y,
  input  logic [9:0]                 probe_s,
  output logic [16:0]                rom_addr,
  input  logic                       rom_q,
  output logic [5*NUM_SPRITES-1:0]   wall_flags,
  output logic                       scan_done,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned WW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int unsigned NF = 5 * NUM_SPRITES;
  localparam int unsigned FW = $clog2(NF);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PUBLISH} state_t;
  typedef enum logic [2:0] {P_CTR, P_RIGHT, P_TOP, P_LEFT, P_BOTTOM} probe_t;

  state_t          state_q, state_d;
  probe_t          probe_q;
  logic [SW-1:0]   sprite_q;
  logic [WW-1:0]   wait_q;
  logic [9:0]      snap_x [NUM_SPRITES];
  logic [9:0]      snap_y [NUM_SPRITES];
  logic [9:0]      snap_s;
  logic [NF-1:0]   scratch_q;

  logic            wait_last, probe_last;
  logic            start_scan, issue_en, sample_en, publish_en;
  logic [FW-1:0]   flag_idx;

  logic [9:0]      cur_x, cur_y, px, py;
  logic [10:0]     x_plus, y_plus;
  logic [13:0]     x_mul;
  logic [12:0]     y_mul;
  logic [16:0]     addr_d;

  assign wait_last  = (wait_q == WW'(ROM_LAT - 1));
  assign probe_last = (probe_q == P_BOTTOM) && (sprite_q == SW'(NUM_SPRITES - 1));
  assign flag_idx   = FW'(sprite_q) * FW'(5) + FW'(probe_q);

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (frame_start) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (wait_last) state_d = probe_last ? S_PUBLISH : S_ISSUE;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    start_scan = (state_q == S_IDLE) && frame_start;
    issue_en   = (state_q == S_ISSUE);
    sample_en  = (state_q == S_WAIT) && wait_last;
    publish_en = (state_q == S_PUBLISH);
  end

  // 300/640 = 15/32 and 300/480 = 5/8, so shift-and-add gives the exact floor.
  always_comb begin
    cur_x  = snap_x[sprite_q];
    cur_y  = snap_y[sprite_q];
    x_plus = {1'b0, cur_x} + {1'b0, snap_s};
    y_plus = {1'b0, cur_y} + {1'b0, snap_s};
    px     = cur_x;
    py     = cur_y;
    case (probe_q)
      P_RIGHT:  px = (x_plus > 11'd639) ? 10'd639 : x_plus[9:0];
      P_TOP:    py = (snap_s > cur_y) ? '0 : cur_y - snap_s;
      P_LEFT:   px = (snap_s > cur_x) ? '0 : cur_x - snap_s;
      P_BOTTOM: py = (y_plus > 11'd479) ? 10'd479 : y_plus[9:0];
      default:  ;
    endcase
    x_mul  = 14'(px) * 14'd15;
    y_mul  = 13'(py) * 13'd5;
    addr_d = 17'(y_mul[12:3]) * 17'd300 + 17'(x_mul[13:5]);
  end

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr   <= '0;
      wall_flags <= '0;
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
      scratch_q  <= '0;
      snap_s     <= '0;
      probe_q    <= P_CTR;
      sprite_q   <= '0;
      wait_q     <= '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
    end else begin
      scan_done <= publish_en;
      overrun   <= frame_start && (state_q != S_IDLE);
      if (start_scan) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          snap_x[i] <= pos_x[10*i +: 10];
          snap_y[i] <= pos_y[10*i +: 10];
        end
        snap_s    <= probe_s;
        probe_q   <= P_CTR;
        sprite_q  <= '0;
        scratch_q <= '0;
      end
      if (issue_en) begin
        rom_addr <= addr_d;
        wait_q   <= '0;
      end
      if ((state_q == S_WAIT) && !wait_last) wait_q <= wait_q + WW'(1);
      if (sample_en) begin
        scratch_q[flag_idx] <= rom_q;
        if (probe_last) begin
          probe_q  <= P_CTR;
          sprite_q <= '0;
        end else if (probe_q == P_BOTTOM) begin
          probe_q  <= P_CTR;
          sprite_q <= sprite_q + SW'(1);
        end else begin
          probe_q  <= probe_t'(probe_q + 3'd1);
        end
      end
      if (publish_en) wall_flags <= scratch_q;
    end
  end

endmodule

// File: tb/tb_maze_probe_sequencer.sv
// Scan-level bench: table of sprite-0 scenarios with hand-derived ROM addresses and flags,
// a queue scoreboard for the 25 probe addresses per scan, plus overrun and mid-scan reset runs.
module tb_maze_probe_sequencer;
  localparam int unsigned N = 5;

  logic              vga_clk = 1'b0;
  logic              Reset_n;
  logic              frame_start;
  logic [10*N-1:0]   pos_x, pos_y;
  logic [9:0]        probe_s;
  logic [16:0]       rom_addr;
  logic              rom_q = 1'b0;
  logic              rom_s1 = 1'b0;
  logic [5*N-1:0]    wall_flags;
  logic              scan_done, busy, overrun;
  logic [16:0]       hit_addr;

  int checks = 0;
  int errors = 0;
  logic [16:0]    sb_q[$];
  logic [5*N-1:0] last_flags;

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [9:0]       s;
    logic [16:0]      hit;
    logic [4:0]       f0;
    logic [4:0][16:0] a;
  } vec_t;

  vec_t tv [5];

  always #5 vga_clk = ~vga_clk;

  maze_probe_sequencer #(.NUM_SPRITES(N), .ROM_LAT(2)) dut (
    .vga_clk     (vga_clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .probe_s     (probe_s),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .wall_flags  (wall_flags),
    .scan_done   (scan_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  // ROM clocked on the falling edge, two stages: valid two rising edges after the address.
  always @(negedge vga_clk) begin
    rom_s1 <= (rom_addr == hit_addr);
    rom_q  <= rom_s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_addr(input int x, input int y, input int s, input int p);
    int px;
    int py;
    px = x;
    py = y;
    case (p)
      1: px = (x + s > 639) ? 639 : x + s;
      2: py = (y - s < 0) ? 0 : y - s;
      3: px = (x - s < 0) ? 0 : x - s;
      4: py = (y + s > 479) ? 479 : y + s;
      default: ;
    endcase
    return 17'((px * 300) / 640 + ((py * 300) / 480) * 300);
  endfunction

  function automatic vec_t mk(input int x, input int y, input int s, input int hit, input int f0,
                              input int a0, input int a1, input int a2, input int a3, input int a4);
    vec_t v;
    v.x = 10'(x);  v.y = 10'(y);  v.s = 10'(s);
    v.hit = 17'(hit);  v.f0 = 5'(f0);
    v.a[0] = 17'(a0);  v.a[1] = 17'(a1);  v.a[2] = 17'(a2);
    v.a[3] = 17'(a3);  v.a[4] = 17'(a4);
    return v;
  endfunction

  task automatic run_scan(input int vi, input int ovr_edge, input int rst_edge);
    vec_t           v;
    logic [5*N-1:0] exp_f;
    logic [16:0]    a;
    logic [16:0]    cur;
    int             x, y;
    v        = tv[vi];
    hit_addr = v.hit;
    probe_s  = v.s;
    exp_f    = '0;
    cur      = '0;
    sb_q.delete();
    for (int s = 0; s < N; s++) begin
      x = (s == 0) ? int'(v.x) : 100 * s;
      y = (s == 0) ? int'(v.y) : 50 * s;
      pos_x[10*s +: 10] = 10'(x);
      pos_y[10*s +: 10] = 10'(y);
      for (int p = 0; p < 5; p++) begin
        a = (s == 0) ? v.a[p] : model_addr(x, y, int'(v.s), p);
        sb_q.push_back(a);
        exp_f[5*s + p] = (s == 0) ? v.f0[p] : (a == v.hit);
      end
    end
    frame_start = 1'b1;
    @(posedge vga_clk);
    #2;
    frame_start = 1'b0;
    pos_x   = 50'({$urandom(), $urandom()});
    pos_y   = 50'({$urandom(), $urandom()});
    probe_s = 10'($urandom());
    chk("busy_rise", 32'(busy), 32'(1));
    for (int n = 1; n <= 80; n++) begin
      @(posedge vga_clk);
      #2;
      if (n == rst_edge) begin
        Reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_flags", 32'(wall_flags), 32'(0));
        chk("abort_done", 32'(scan_done), 32'(0));
        chk("abort_addr", 32'(rom_addr), 32'(0));
        last_flags = '0;
        repeat (3) @(posedge vga_clk);
        #2;
        Reset_n = 1'b1;
        sb_q.delete();
        return;
      end
      chk("busy", 32'(busy), 32'(n <= 75));
      chk("scan_done", 32'(scan_done), 32'(n == 76));
      chk("overrun", 32'(overrun), 32'(n == ovr_edge));
      if (n <= 75) begin
        if ((n - 1) % 3 == 0) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: no expected address left at cycle %0d", n);
          end else begin
            cur = sb_q.pop_front();
          end
        end
        chk("rom_addr", 32'(rom_addr), 32'(cur));
        chk("flags_hold", 32'(wall_flags), 32'(last_flags));
      end
      if (n == 76) begin
        chk("wall_flags", 32'(wall_flags), 32'(exp_f));
        chk("sb_left", 32'(sb_q.size()), 32'(0));
        last_flags = exp_f;
      end
      if (n == ovr_edge - 1) frame_start = 1'b1;
      if (n == ovr_edge)     frame_start = 1'b0;
    end
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    pos_x       = '0;
    pos_y       = '0;
    probe_s     = '0;
    hit_addr    = '1;
    last_flags  = '0;

    tv[0] = mk(320, 260, 6, 17'h1FFFF, 5'b00000, 48750, 48752, 47550, 48747, 49950);
    tv[1] = mk(320, 260, 6, 48752,     5'b00010, 48750, 48752, 47550, 48747, 49950);
    tv[2] = mk(3,   240, 6, 17'h1FFFF, 5'b00000, 45001, 45004, 43801, 45000, 45901);
    tv[3] = mk(636, 476, 6, 89998,     5'b10000, 89398, 89399, 88198, 89395, 89998);
    tv[4] = mk(0,   0,   6, 0,         5'b01101, 0,     2,     0,     0,     900);

    repeat (3) @(posedge vga_clk);
    #2;
    chk("rst_addr", 32'(rom_addr), 32'(0));
    chk("rst_flags", 32'(wall_flags), 32'(0));
    chk("rst_done", 32'(scan_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    Reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge vga_clk);
      #2;
      chk("idle_busy", 32'(busy), 32'(0));
    end

    for (int vi = 0; vi < 5; vi++) begin
      run_scan(vi, -1, -1);
      repeat (3) @(posedge vga_clk);
      #2;
    end

    run_scan(0, 10, -1);
    for (int i = 0; i < 20; i++) begin
      @(posedge vga_clk);
      #2;
      chk("no_rescan_busy", 32'(busy), 32'(0));
      chk("no_rescan_done", 32'(scan_done), 32'(0));
    end

    run_scan(1, -1, -1);
    run_scan(0, -1, 40);
    run_scan(3, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
